// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: widths, opcode encodings and FSM states.
package exec_pkg;

  localparam int DATA_W = 8;
  localparam int AW     = 5;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  // Single-cycle ALU opcodes occupy the contiguous range ADD..SLTU.
  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= OP_SLTU;
  endfunction

endpackage

// File: rtl/mul_seq8.sv
// Iterative shift-add multiplier; done and product are valid in the cycle of the final iteration.
module mul_seq8
  import exec_pkg::*;
#(
  parameter int DATA_W = exec_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] acc;
  logic [CW-1:0]     count;
  logic              running;
  logic [DATA_W-1:0] acc_next;

  // product exposes the accumulator including the current iteration so the
  // caller can capture the result on the same edge as the last step.
  assign acc_next = acc + (b_r[0] ? a_r : '0);
  assign product  = acc_next;
  assign done     = running && (count == CW'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      acc     <= '0;
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      a_r     <= a;
      b_r     <= b;
      acc     <= '0;
      count   <= '0;
      running <= 1'b1;
    end else if (running) begin
      acc   <= acc_next;
      a_r   <= a_r << 1;
      b_r   <= b_r >> 1;
      count <= count + CW'(1);
      if (done) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU plus iterative multiply, with a registered
// one-cycle register-file writeback.
module exec_unit
  import exec_pkg::*;
#(
  parameter int DATA_W = exec_pkg::DATA_W,
  parameter int AW     = exec_pkg::AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] rs1_val,
  input  logic [DATA_W-1:0] rs2_val,
  input  logic [AW-1:0]     rd,
  output logic              wb_we,
  output logic [AW-1:0]     wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              illegal_op
);

  state_t            state;
  logic [AW-1:0]     mul_rd;
  logic [DATA_W-1:0] alu_res;
  logic [2:0]        shamt;
  logic              accept;
  logic              mul_start;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state == S_MUL);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);
  assign shamt     = rs2_val[2:0];

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = rs1_val + rs2_val;
      OP_SUB:  alu_res = rs1_val - rs2_val;
      OP_AND:  alu_res = rs1_val & rs2_val;
      OP_OR:   alu_res = rs1_val | rs2_val;
      OP_XOR:  alu_res = rs1_val ^ rs2_val;
      OP_SLL:  alu_res = rs1_val << shamt;
      OP_SRL:  alu_res = rs1_val >> shamt;
      OP_SRA:  alu_res = $signed(rs1_val) >>> shamt;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(rs1_val) < $signed(rs2_val))};
      OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (rs1_val < rs2_val)};
      default: alu_res = '0;
    endcase
  end

  mul_seq8 #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (rs1_val),
    .b       (rs2_val),
    .done    (mul_done),
    .product (mul_product)
  );

  // Writes to x0 are computed but never reach the register file; the address
  // and data registers only move when a real write is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      mul_rd     <= '0;
      wb_we      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      illegal_op <= 1'b0;
    end else begin
      wb_we      <= 1'b0;
      illegal_op <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state  <= S_MUL;
              mul_rd <= rd;
            end else if (is_alu_op(op)) begin
              if (rd != '0) begin
                wb_we   <= 1'b1;
                wb_addr <= rd;
                wb_data <= alu_res;
              end
            end else begin
              illegal_op <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (mul_done) begin
            state <= S_IDLE;
            if (mul_rd != '0) begin
              wb_we   <= 1'b1;
              wb_addr <= mul_rd;
              wb_data <= mul_product;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: table-driven ALU vectors plus multiply,
// reset-abort and dropped-request sequences.
module tb_exec_unit;
  import exec_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] rs1_val;
  logic [7:0] rs2_val;
  logic [4:0] rd;
  logic       wb_we;
  logic [4:0] wb_addr;
  logic [7:0] wb_data;
  logic       busy;
  logic       illegal_op;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] rd;
    logic       we;
    logic [7:0] data;
    logic       ill;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  exec_unit dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .rs1_val    (rs1_val),
    .rs2_val    (rs2_val),
    .rd         (rd),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .busy       (busy),
    .illegal_op (illegal_op)
  );

  function automatic vec_t mk(input string name, input logic [3:0] o, input logic [7:0] a,
                              input logic [7:0] b, input logic [4:0] r, input logic we,
                              input logic [7:0] data, input logic ill);
    vec_t v;
    v.name = name; v.op = o; v.a = a; v.b = b; v.rd = r;
    v.we = we; v.data = data; v.ill = ill;
    return v;
  endfunction

  task automatic applyStimulus(input logic v, input logic [3:0] o, input logic [7:0] a,
                               input logic [7:0] b, input logic [4:0] r);
    @(negedge clk);
    in_valid = v;
    op       = o;
    rs1_val  = a;
    rs2_val  = b;
    rd       = r;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_we"},    32'(wb_we),    32'd0);
    checkOutput({tag, "_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_busy"},  32'(busy),     32'd0);
  endtask

  // Issues a multiply, checks the stall window (injecting an ignored ADD in
  // the middle), then checks the writeback in cycle N+9.
  task automatic runMul(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [4:0] r, input logic [7:0] expd);
    applyStimulus(1'b1, OP_MUL, a, b, r);
    @(posedge clk); #1;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) begin
        applyStimulus(k == 3, OP_ADD, 8'h11, 8'h22, 5'd9);
        @(posedge clk); #1;
      end
      checkOutput($sformatf("%s_ready_c%0d", name, k), 32'(in_ready), 32'd0);
      checkOutput($sformatf("%s_busy_c%0d", name, k),  32'(busy),     32'd1);
      checkOutput($sformatf("%s_we_c%0d", name, k),    32'(wb_we),    32'd0);
    end
    applyStimulus(1'b0, OP_ADD, 8'h00, 8'h00, 5'd0);
    @(posedge clk); #1;
    checkOutput({name, "_wb_we"},   32'(wb_we),    32'd1);
    checkOutput({name, "_wb_addr"}, 32'(wb_addr),  32'(r));
    checkOutput({name, "_wb_data"}, 32'(wb_data),  32'(expd));
    checkOutput({name, "_ready"},   32'(in_ready), 32'd1);
    checkOutput({name, "_busy"},    32'(busy),     32'd0);
  endtask

  initial begin
    vecs[0]  = mk("add",      OP_ADD,  8'hF0, 8'h20, 5'd3,  1'b1, 8'h10, 1'b0);
    vecs[1]  = mk("sub",      OP_SUB,  8'h05, 8'h07, 5'd4,  1'b1, 8'hFE, 1'b0);
    vecs[2]  = mk("sra",      OP_SRA,  8'h80, 8'h0B, 5'd5,  1'b1, 8'hF0, 1'b0);
    vecs[3]  = mk("slt",      OP_SLT,  8'hFF, 8'h01, 5'd6,  1'b1, 8'h01, 1'b0);
    vecs[4]  = mk("sltu",     OP_SLTU, 8'hFF, 8'h01, 5'd7,  1'b1, 8'h00, 1'b0);
    vecs[5]  = mk("and",      OP_AND,  8'hF0, 8'h3C, 5'd8,  1'b1, 8'h30, 1'b0);
    vecs[6]  = mk("or",       OP_OR,   8'hF0, 8'h0F, 5'd9,  1'b1, 8'hFF, 1'b0);
    vecs[7]  = mk("xor",      OP_XOR,  8'hFF, 8'h0F, 5'd10, 1'b1, 8'hF0, 1'b0);
    vecs[8]  = mk("sll",      OP_SLL,  8'h01, 8'h0F, 5'd11, 1'b1, 8'h80, 1'b0);
    vecs[9]  = mk("add_x0",   OP_ADD,  8'h12, 8'h34, 5'd0,  1'b0, 8'h00, 1'b0);
    vecs[10] = mk("illegal",  4'hF,    8'h12, 8'h34, 5'd12, 1'b0, 8'h00, 1'b1);
    vecs[11] = mk("srl",      OP_SRL,  8'h80, 8'h0A, 5'd31, 1'b1, 8'h20, 1'b0);

    rst      = 1'b1;
    in_valid = 1'b0;
    op       = OP_ADD;
    rs1_val  = 8'h00;
    rs2_val  = 8'h00;
    rd       = 5'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkIdle($sformatf("reset_c%0d", i));
      checkOutput($sformatf("reset_data_c%0d", i), 32'(wb_data), 32'd0);
    end

    $display("[TB] ALU vector table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
      @(posedge clk); #1;
      checkOutput({vecs[i].name, "_we"},    32'(wb_we),      32'(vecs[i].we));
      checkOutput({vecs[i].name, "_ill"},   32'(illegal_op), 32'(vecs[i].ill));
      checkOutput({vecs[i].name, "_ready"}, 32'(in_ready),   32'd1);
      if (vecs[i].we) begin
        checkOutput({vecs[i].name, "_addr"}, 32'(wb_addr), 32'(vecs[i].rd));
        checkOutput({vecs[i].name, "_data"}, 32'(wb_data), 32'(vecs[i].data));
      end
    end
    applyStimulus(1'b0, OP_ADD, 8'h00, 8'h00, 5'd0);
    @(posedge clk); #1;
    checkOutput("post_table_we",  32'(wb_we),      32'd0);
    checkOutput("post_table_ill", 32'(illegal_op), 32'd0);

    $display("[TB] multiply sequences");
    runMul("mul_13x11", 8'd13, 8'd11, 5'd7, 8'h8F);
    runMul("mul_ffxff", 8'hFF, 8'hFF, 5'd14, 8'h01);
    @(posedge clk); #1;
    checkOutput("mul_no_extra_we", 32'(wb_we), 32'd0);

    $display("[TB] reset during multiply");
    applyStimulus(1'b1, OP_MUL, 8'd3, 8'd5, 5'd8);
    @(posedge clk);
    applyStimulus(1'b0, OP_ADD, 8'h00, 8'h00, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkIdle("abort");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("abort_we_c%0d", i), 32'(wb_we), 32'd0);
    end
    applyStimulus(1'b1, OP_ADD, 8'h01, 8'h02, 5'd2);
    @(posedge clk); #1;
    checkOutput("after_abort_we",   32'(wb_we),   32'd1);
    checkOutput("after_abort_addr", 32'(wb_addr), 32'd2);
    checkOutput("after_abort_data", 32'(wb_data), 32'd3);
    applyStimulus(1'b0, OP_ADD, 8'h00, 8'h00, 5'd0);
    @(posedge clk); #1;
    checkOutput("after_abort_pulse", 32'(wb_we), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
